rd16_share_arb: RTL and testbench

- Time-shares one 16-bit recursive-doubling adder (rd16) between NREQ requesters, e.g. the Wallace-tree final-add stage, the PC incrementer and the ALU add path.
- Round-robin arbitration on a valid/ready request channel.
- Registered operands into the combinational adder, then a single tagged response channel with valid/ready.
- Sits beside the adder: the adder is instantiated externally and wired through the add_* ports.

---
 rtl/rd16_pkg.sv | 23 ++
 rtl/rr_arb.sv | 38 +++
 rtl/rd16_share_arb.sv | 140 ++++++++++++++
 tb/tb_rd16_share_arb.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/rd16_pkg.sv
// Shared definitions for the rd16 adder-sharing arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rd16_pkg;

    localparam int W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arb.sv
// Combinational round-robin picker: first valid requester at or after rr_ptr.
// Latency: zero cycles, purely combinational.
// Backpressure: none; the caller decides whether the grant is consumed.
module rr_arb
    import rd16_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [IDW-1:0]  rr_ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx,
    output logic            grant_vld
);

    localparam int CW = IDW + 1;

    logic [CW-1:0] cand;

    // The wider candidate index lets rr_ptr+k wrap at NREQ even when NREQ is not a power of two.
    always_comb begin
        grant_idx = '0;
        grant_vld = 1'b0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, rr_ptr} + CW'(k);
            if (cand >= CW'(NREQ)) cand = cand - CW'(NREQ);
            if (!grant_vld && req_valid[cand[IDW-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = cand[IDW-1:0];
            end
        end
        grant = '0;
        if (grant_vld) grant[grant_idx] = 1'b1;
    end

endmodule

// File: rtl/rd16_share_arb.sv
// Time-shares one external 16-bit adder between NREQ round-robin requesters.
// Latency: accept edge -> CALC, next edge -> rsp_valid; one op per 2 cycles sustained.
// Backpressure: response held while rsp_ready=0; no new request accepted until it drains.
module rd16_share_arb
    import rd16_pkg::*;
#(
    parameter int  NREQ = 4,
    localparam int IDW  = clog2(NREQ)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*W-1:0]   req_a,
    input  logic [NREQ*W-1:0]   req_b,
    output logic [W-1:0]        add_a,
    output logic [W-1:0]        add_b,
    input  logic [W-1:0]        add_sum,
    input  logic                add_carry,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [W-1:0]        rsp_sum,
    output logic                rsp_carry,
    output logic [IDW-1:0]      rsp_id,
    output logic                busy,
    output logic [15:0]         op_count
);

    state_t          state_q, state_d;
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [W-1:0]    op_a_q, op_a_d;
    logic [W-1:0]    op_b_q, op_b_d;
    logic [IDW-1:0]  op_id_q, op_id_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [W-1:0]    rsp_sum_q, rsp_sum_d;
    logic            rsp_carry_q, rsp_carry_d;
    logic [IDW-1:0]  rsp_id_q, rsp_id_d;
    logic [15:0]     op_count_q, op_count_d;

    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_idx;
    logic            grant_vld;
    logic            can_accept;
    logic            accept;

    rr_arb #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_arb (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld)
    );

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        op_id_d     = op_id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_carry_d = rsp_carry_q;
        rsp_id_d    = rsp_id_q;
        op_count_d  = op_count_q;
        can_accept  = 1'b0;

        case (state_q)
            CALC: begin
                rsp_sum_d   = add_sum;
                rsp_carry_d = add_carry;
                rsp_id_d    = op_id_q;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    op_count_d  = op_count_q + 16'd1;
                    can_accept  = 1'b1;
                    state_d     = IDLE;
                end
            end
            // IDLE, and the unused encoding recovers as IDLE.
            default: begin
                can_accept = 1'b1;
                state_d    = IDLE;
            end
        endcase

        accept = can_accept && grant_vld;
        if (accept) begin
            op_a_d   = req_a[int'(grant_idx)*W +: W];
            op_b_d   = req_b[int'(grant_idx)*W +: W];
            op_id_d  = grant_idx;
            rr_ptr_d = (grant_idx == IDW'(NREQ-1)) ? '0 : grant_idx + 1'b1;
            state_d  = CALC;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_id_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_sum_q   <= '0;
            rsp_carry_q <= 1'b0;
            rsp_id_q    <= '0;
            op_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            op_id_q     <= op_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_carry_q <= rsp_carry_d;
            rsp_id_q    <= rsp_id_d;
            op_count_q  <= op_count_d;
        end
    end

    // Ready is held low while reset is asserted, even though the state already reads IDLE.
    assign req_ready = (accept && rst_n) ? grant : '0;
    assign add_a     = op_a_q;
    assign add_b     = op_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_carry = rsp_carry_q;
    assign rsp_id    = rsp_id_q;
    assign op_count  = op_count_q;
    assign busy      = (state_q == CALC) || (state_q == RESP);

endmodule

// File: tb/tb_rd16_share_arb.sv
// Self-checking bench for rd16_share_arb against a cycle-level behavioural model.
module tb_rd16_share_arb;

    localparam int NREQ = 4;
    localparam int W    = 16;
    localparam int IDW  = 2;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*W-1:0]   req_a, req_b;
    logic [W-1:0]        add_a, add_b, add_sum, rsp_sum;
    logic                add_carry, rsp_valid, rsp_ready, rsp_carry, busy;
    logic [IDW-1:0]      rsp_id;
    logic [15:0]         op_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // External adder model.
    assign {add_carry, add_sum} = {1'b0, add_a} + {1'b0, add_b};

    rd16_share_arb #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_sum   (add_sum),
        .add_carry (add_carry),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_carry (rsp_carry),
        .rsp_id    (rsp_id),
        .busy      (busy),
        .op_count  (op_count)
    );

    // Behavioural model: an op "in the adder", a pending response, a pointer and a counter.
    int          m_ptr;
    bit          m_calc;
    logic [15:0] m_ca, m_cb;
    int          m_cid;
    bit          m_rv;
    logic [15:0] m_rs;
    logic        m_rc;
    int          m_rid;
    logic [15:0] m_cnt;

    task automatic model_reset();
        m_ptr = 0; m_calc = 0; m_ca = 0; m_cb = 0; m_cid = 0;
        m_rv = 0; m_rs = 0; m_rc = 0; m_rid = 0; m_cnt = 0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int winner(input logic [NREQ-1:0] v);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        end
        return -1;
    endfunction

    // One cycle: drive at negedge, compare against the model, then advance the model over the next edge.
    task automatic step(input logic [NREQ-1:0] v, input logic [NREQ*W-1:0] a,
                        input logic [NREQ*W-1:0] b, input logic rr);
        int              g;
        bit              ok;
        logic [NREQ-1:0] exp_rdy;
        logic [16:0]     s;
        @(negedge clk);
        req_valid = v; req_a = a; req_b = b; rsp_ready = rr;
        #1;
        g  = winner(v);
        ok = !m_calc && (!m_rv || rr);
        exp_rdy = '0;
        if (ok && g >= 0) exp_rdy[g] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        chk("add_a", 32'(add_a), 32'(m_ca));
        chk("add_b", 32'(add_b), 32'(m_cb));
        chk("rsp_valid", 32'(rsp_valid), 32'(m_rv));
        chk("rsp_sum", 32'(rsp_sum), 32'(m_rs));
        chk("rsp_carry", 32'(rsp_carry), 32'(m_rc));
        chk("rsp_id", 32'(rsp_id), 32'(m_rid));
        chk("busy", 32'(busy), 32'(m_calc || m_rv));
        chk("op_count", 32'(op_count), 32'(m_cnt));
        if (m_calc) begin
            s = {1'b0, m_ca} + {1'b0, m_cb};
            m_rs = s[15:0]; m_rc = s[16]; m_rid = m_cid; m_rv = 1; m_calc = 0;
        end else if (m_rv && rr) begin
            m_rv = 0; m_cnt = m_cnt + 16'd1;
        end
        if (ok && g >= 0) begin
            m_ca = a[g*W +: W]; m_cb = b[g*W +: W]; m_cid = g; m_calc = 1;
            m_ptr = (g + 1) % NREQ;
        end
    endtask

    task automatic rsp_lit(input string name, input logic [15:0] s, input logic c, input int id);
        chk({name, "_valid"}, 32'(rsp_valid), 32'd1);
        chk({name, "_sum"}, 32'(rsp_sum), 32'(s));
        chk({name, "_carry"}, 32'(rsp_carry), 32'(c));
        chk({name, "_id"}, 32'(rsp_id), 32'(id));
    endtask

    function automatic logic [NREQ*W-1:0] rnd_vec();
        logic [NREQ*W-1:0] r;
        for (int i = 0; i < NREQ; i++) r[i*W +: W] = 16'($urandom);
        return r;
    endfunction

    logic [NREQ*W-1:0] va, vb;
    logic [NREQ*W-1:0] z;
    int                ids[$];

    initial begin
        z = '0;
        rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
        model_reset();
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_op_count", 32'(op_count), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single request on requester 0.
        va = '0; vb = '0; va[15:0] = 16'h1234; vb[15:0] = 16'h4321;
        step(4'b0001, va, vb, 1'b1);
        step(4'b0000, va, vb, 1'b1);
        step(4'b0000, va, vb, 1'b1);
        rsp_lit("single", 16'h5555, 1'b0, 0);
        step(4'b0000, va, vb, 1'b1);
        chk("single_op_count", 32'(op_count), 32'd1);

        // Carry-out on requester 2.
        va = '0; vb = '0; va[47:32] = 16'hFFFF; vb[47:32] = 16'h0001;
        step(4'b0100, va, vb, 1'b1);
        step(4'b0000, va, vb, 1'b1);
        step(4'b0000, va, vb, 1'b1);
        rsp_lit("carry", 16'h0000, 1'b1, 2);
        step(4'b0000, va, vb, 1'b1);

        // Back-pressure with requester 1 pending.
        va = '0; vb = '0;
        va[15:0] = 16'h0100; vb[15:0] = 16'h0200;
        va[31:16] = 16'h0007; vb[31:16] = 16'h0008;
        step(4'b0001, va, vb, 1'b0);
        step(4'b0000, va, vb, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(4'b0010, va, vb, 1'b0);
            rsp_lit("bp_hold", 16'h0300, 1'b0, 0);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
        end
        step(4'b0010, va, vb, 1'b1);
        chk("bp_accept", 32'(req_ready), 32'b0010);
        step(4'b0000, va, vb, 1'b1);
        step(4'b0000, va, vb, 1'b1);
        rsp_lit("bp_rsp", 16'h000F, 1'b0, 1);
        step(4'b0000, va, vb, 1'b1);

        // Asynchronous reset while an op sits in CALC.
        va = '0; vb = '0; va[15:0] = 16'hAAAA; vb[15:0] = 16'h5555;
        step(4'b0001, va, vb, 1'b1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        req_valid = 4'b1000;
        #1;
        chk("arst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_op_count", 32'(op_count), 32'd0);
        chk("arst_req_ready", 32'(req_ready), 32'd0);
        chk("arst_add_a", 32'(add_a), 32'd0);
        chk("arst_rsp_sum", 32'(rsp_sum), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        req_valid = '0;
        va = '0; vb = '0; va[63:48] = 16'h8001; vb[63:48] = 16'h8002;
        step(4'b1000, va, vb, 1'b1);
        step(4'b0000, va, vb, 1'b1);
        step(4'b0000, va, vb, 1'b1);
        rsp_lit("post_rst", 16'h0003, 1'b1, 3);
        step(4'b0000, va, vb, 1'b1);

        // Round-robin with all requesters continuously valid.
        for (int i = 0; i < 10; i++) begin
            step(4'b1111, rnd_vec(), rnd_vec(), 1'b1);
            if (rsp_valid) ids.push_back(int'(rsp_id));
        end
        chk("rr_count", 32'(ids.size()), 32'd4);
        for (int i = 0; i < 4 && i < ids.size(); i++) chk("rr_order", 32'(ids[i]), 32'(i));
        step(4'b0000, z, z, 1'b1);
        step(4'b0000, z, z, 1'b1);

        // Counter wrap.
        @(negedge clk);
        force dut.op_count_q = 16'hFFFF;
        @(posedge clk);
        @(negedge clk);
        release dut.op_count_q;
        m_cnt = 16'hFFFF;
        step(4'b0100, rnd_vec(), rnd_vec(), 1'b1);
        chk("wrap_pre", 32'(op_count), 32'hFFFF);
        step(4'b0000, z, z, 1'b1);
        step(4'b0000, z, z, 1'b1);
        step(4'b0000, z, z, 1'b1);
        chk("wrap_post", 32'(op_count), 32'h0000);

        // Randomized traffic with random back-pressure.
        for (int i = 0; i < 4000; i++) begin
            step(NREQ'($urandom_range(0, (1 << NREQ) - 1)), rnd_vec(), rnd_vec(),
                 ($urandom_range(0, 3) != 0));
        end
        for (int i = 0; i < 4; i++) step(4'b0000, z, z, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
